// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner and single-outstanding instruction fetch controller for the RV32i core.
// Optional FETCH_MISALIGN_TRAP_EN: trap misaligned targets instead of forcing them to word alignment.
module fetch_sequencer #(
    parameter int MEM_ADDR_WIDTH = 10,
    parameter logic [MEM_ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      stall_i,
    input  logic                      redirect_i,
    input  logic                      redirect_abs_i,
    input  logic [MEM_ADDR_WIDTH-1:0] redirect_pc_i,
    input  logic [MEM_ADDR_WIDTH-1:0] redirect_off_i,
    output logic                      imem_req_o,
    output logic [MEM_ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                      imem_gnt_i,
    input  logic                      imem_rvalid_i,
    input  logic [31:0]               imem_rdata_i,
    output logic                      instr_valid_o,
    output logic [31:0]               instr_o,
    output logic [MEM_ADDR_WIDTH-1:0] instr_pc_o,
    input  logic                      instr_ready_i,
    output logic                      fetch_misalign_o
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    state_t state;
    logic [MEM_ADDR_WIDTH-1:0] pc, pend_target, target, load_t, load_aligned;
    logic squash, misalign, load_bad;

    assign target = redirect_abs_i ? redirect_off_i : redirect_pc_i + redirect_off_i;
    // A squashed fetch resolves to the pending target unless a newer redirect arrives with rvalid.
    assign load_t = (state == WAIT && !redirect_i) ? pend_target : target;
    assign load_aligned = {load_t[MEM_ADDR_WIDTH-1:2], 2'b00};
    assign load_bad = TRAP && (load_t[1:0] != 2'b00);

    assign imem_req_o = state == REQ;
    assign imem_addr_o = pc;
    assign instr_valid_o = state == HOLD;
    assign fetch_misalign_o = misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc <= RESET_ADDR;
            pend_target <= '0;
            squash <= 1'b0;
            misalign <= 1'b0;
            instr_o <= '0;
            instr_pc_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect_i) begin
                        if (!load_bad) pc <= load_aligned;
                        misalign <= load_bad;
                    end else if (!stall_i && !misalign) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (redirect_i) begin
                        squash <= 1'b1;
                        pend_target <= target;
                    end
                    if (imem_gnt_i) state <= WAIT;
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        if (squash || redirect_i) begin
                            if (!load_bad) pc <= load_aligned;
                            misalign <= load_bad;
                            squash <= 1'b0;
                            state <= IDLE;
                        end else begin
                            instr_o <= imem_rdata_i;
                            instr_pc_o <= pc;
                            state <= HOLD;
                        end
                    end else if (redirect_i) begin
                        squash <= 1'b1;
                        pend_target <= target;
                    end
                end
                HOLD: begin
                    if (redirect_i) begin
                        if (!load_bad) pc <= load_aligned;
                        misalign <= load_bad;
                        state <= IDLE;
                    end else if (instr_ready_i) begin
                        pc <= pc + MEM_ADDR_WIDTH'(4);
                        state <= stall_i ? IDLE : REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scoreboard bench; expected fetch addresses and delivered instructions are
// queued as stimulus is driven and popped as the memory model grants and decode accepts.
module tb_fetch_sequencer;
    localparam int W = 10;

    logic clk = 0, rst_n = 0, stall = 1, redirect = 0, redirect_abs = 0;
    logic [W-1:0] redirect_pc = '0, redirect_off = '0;
    logic imem_req, imem_gnt = 0, imem_rvalid = 0;
    logic [W-1:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic instr_valid, instr_ready = 1, fetch_misalign;
    logic [31:0] instr;
    logic [W-1:0] instr_pc;

    int vectors = 0, miscompares = 0;
    logic [W-1:0] exp_addr[$], exp_pc[$];
    logic [31:0] exp_data[$];
    int gnt_delay = 0, rv_delay = 0, wait_cnt = 0, rv_cnt = -1, cyc = 0, first_req = -1, first_valid = -1;
    logic [W-1:0] rv_addr = '0;

    fetch_sequencer #(.MEM_ADDR_WIDTH(W), .RESET_ADDR('0)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall), .redirect_i(redirect),
        .redirect_abs_i(redirect_abs), .redirect_pc_i(redirect_pc), .redirect_off_i(redirect_off),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(imem_gnt),
        .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata), .instr_valid_o(instr_valid),
        .instr_o(instr), .instr_pc_o(instr_pc), .instr_ready_i(instr_ready),
        .fetch_misalign_o(fetch_misalign)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] data_of(logic [W-1:0] a);
        return 32'h1300_0000 | 32'(a);
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model and decode-side monitor, both acting on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            imem_gnt = 0;
            imem_rvalid = 0;
            wait_cnt = 0;
            rv_cnt = -1;
        end else begin
            imem_rvalid = 0;
            if (rv_cnt == 0) begin
                imem_rvalid = 1;
                imem_rdata = data_of(rv_addr);
                rv_cnt = -1;
            end else if (rv_cnt > 0) rv_cnt--;
            imem_gnt = 0;
            if (imem_req) begin
                if (first_req < 0) first_req = cyc;
                if (wait_cnt >= gnt_delay) begin
                    imem_gnt = 1;
                    wait_cnt = 0;
                    rv_cnt = rv_delay;
                    rv_addr = imem_addr;
                    if (exp_addr.size() == 0) check("spurious_req", {31'b0, imem_req}, 0);
                    else check("req_addr", imem_addr, exp_addr.pop_front());
                end else wait_cnt++;
            end
            if (instr_valid && first_valid < 0) first_valid = cyc;
            if (instr_valid && instr_ready && !redirect) begin
                if (exp_pc.size() == 0) check("spurious_instr", {31'b0, instr_valid}, 0);
                else begin
                    check("instr_pc", instr_pc, exp_pc.pop_front());
                    check("instr_data", instr, exp_data.pop_front());
                end
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(logic [W-1:0] a, bit deliver);
        exp_addr.push_back(a);
        if (deliver) begin
            exp_pc.push_back(a);
            exp_data.push_back(data_of(a));
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_addr.size() + exp_pc.size()) != 0 && n < 50) begin
            tick();
            n++;
        end
        check("drain", exp_addr.size() + exp_pc.size(), 0);
        tick(2);
    endtask

    task automatic single(logic [W-1:0] a);
        push(a, 1);
        stall = 0;
        tick();
        stall = 1;
        drain();
    endtask

    task automatic redir(bit abs, logic [W-1:0] p, logic [W-1:0] off);
        redirect = 1;
        redirect_abs = abs;
        redirect_pc = p;
        redirect_off = off;
        tick();
        redirect = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        stall = 0;
        tick(2);
        check("rst_req", imem_req, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_instr", instr, 0);
        check("rst_instr_pc", instr_pc, 0);
        check("rst_misalign", fetch_misalign, 0);

        // Back-to-back stream from reset, then park with stall.
        push(0, 1); push(4, 1); push(8, 1);
        rst_n = 1;
        n = 0;
        while (exp_pc.size() > 1 && n < 50) begin tick(); n++; end
        stall = 1;
        drain();
        check("latency", first_valid - first_req, 2);
        check("pc_after_stream", imem_addr, 12);

        // Stall after reset holds off the first request.
        rst_n = 0;
        tick();
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin tick(); check("stall_noreq", imem_req, 0); end
        check("stall_addr", imem_addr, 0);
        single(0);

        // Relative redirect while waiting for data: data dropped, refetch at 0x030.
        rv_delay = 2;
        push(4, 0);
        stall = 0; tick(); stall = 1; tick();
        redir(0, 10'h010, 10'h020);
        for (int i = 0; i < 5; i++) begin tick(); check("squash_novalid", instr_valid, 0); end
        check("squash_target", imem_addr, 10'h030);
        rv_delay = 0;
        single(10'h030);

        // Redirect beats ready in HOLD.
        instr_ready = 0;
        push(10'h034, 0);
        stall = 0; tick(); stall = 1;
        n = 0;
        while (!instr_valid && n < 20) begin tick(); n++; end
        check("hold_valid", instr_valid, 1);
        check("hold_pc", instr_pc, 10'h034);
        check("hold_data", instr, data_of(10'h034));
        tick(2);
        check("hold_stable_valid", instr_valid, 1);
        check("hold_stable_pc", instr_pc, 10'h034);
        instr_ready = 1;
        redir(1, 0, 10'h100);
        check("redir_drop", instr_valid, 0);
        check("redir_hold_target", imem_addr, 10'h100);
        single(10'h100);

        // Slow grant with two redirects in REQ: address stable, latest target wins.
        gnt_delay = 3;
        push(10'h104, 0);
        stall = 0; tick(); stall = 1;
        redirect = 1; redirect_abs = 1; redirect_off = 10'h040;
        tick();
        check("req_stable_addr1", imem_addr, 10'h104);
        check("req_held1", imem_req, 1);
        redirect_off = 10'h080;
        tick();
        redirect = 0;
        check("req_stable_addr2", imem_addr, 10'h104);
        check("req_held2", imem_req, 1);
        tick();
        check("req_stable_addr3", imem_addr, 10'h104);
        tick(6);
        check("latest_target", imem_addr, 10'h080);
        gnt_delay = 0;
        single(10'h080);

        // Misaligned absolute target.
        redir(1, 0, 10'h3FE);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("misalign_set", fetch_misalign, 1);
        check("misalign_pc_kept", imem_addr, 10'h084);
        stall = 0;
        for (int i = 0; i < 5; i++) begin tick(); check("misalign_noreq", imem_req, 0); end
        stall = 1;
        redir(1, 0, 10'h200);
        check("misalign_clear", fetch_misalign, 0);
        check("aligned_target", imem_addr, 10'h200);
        single(10'h200);
`else
        check("misalign_forced", imem_addr, 10'h3FC);
        check("misalign_tied0", fetch_misalign, 0);
        single(10'h3FC);
        check("pc_wrap", imem_addr, 0);
`endif

        // Relative target wraps modulo 2^W.
        redir(0, 10'h3F0, 10'h020);
        check("target_wrap", imem_addr, 10'h010);

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
